// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-side bundle for uart_tx_feeder.
// master: the system producer plus transmitter status (drives WR_*, Busy, OVF_CLR).
// slave : the feeder itself (drives P_DATA, DATA_VALID and FIFO status).
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_EN;
  logic                  Busy;
  logic                  OVF_CLR;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  FULL;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVF;

  modport master (
    output WR_DATA, WR_EN, Busy, OVF_CLR,
    input  P_DATA, DATA_VALID, FULL, EMPTY, COUNT, OVF
  );

  modport slave (
    input  WR_DATA, WR_EN, Busy, OVF_CLR,
    output P_DATA, DATA_VALID, FULL, EMPTY, COUNT, OVF
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: synchronous FIFO in front of a UART transmitter.
// Each buffered word is handed over as a one-cycle DATA_VALID pulse with
// P_DATA held until the next pop. After a pulse the FSM waits for Busy to
// rise and then fall, so a new word is only offered to an idle transmitter.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_feeder_if.slave    bus
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Storage and pointers
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  // Issue side
  state_t                state_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  dv_q;

  logic                  full, empty;
  logic                  wr_accept, wr_drop, pop;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // FULL is judged on the registered count, so a pop in the same cycle
  // never frees room for a write that arrived while full.
  assign wr_accept = bus.WR_EN & ~full;
  assign wr_drop   = bus.WR_EN &  full;

  // The only pop is the IDLE->ISSUE step of the FSM.
  assign pop = (state_q == IDLE) & ~empty & ~bus.Busy;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (wr_accept && !pop)      count_d = count_q + CW'(1);
    else if (!wr_accept && pop) count_d = count_q - CW'(1);
    // set has priority over clear when both happen together
    if (bus.OVF_CLR) ovf_d = 1'b0;
    if (wr_drop)     ovf_d = 1'b1;
  end

  // FIFO control registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Word storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.WR_DATA;
  end

  // Issue FSM: one-cycle DATA_VALID per word, then follow Busy through the frame.
  // Busy is not looked at in ISSUE because the transmitter only reacts to
  // DATA_VALID at the end of that cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      p_data_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            p_data_q <= head;
            dv_q     <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE:     state_q <= WAIT_BUSY;
        WAIT_BUSY: if (bus.Busy)  state_q <= WAIT_DONE;
        WAIT_DONE: if (!bus.Busy) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.COUNT      = count_q;
  assign bus.OVF        = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a vector table for the single-word and
// full/pop-collision cases, plus scripted sequences with a small transmitter
// model (Busy for 10 cycles, starting the cycle after it sees DATA_VALID).
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       busy;
    logic       clr;
    logic       dv;
    logic [7:0] pd;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  // transmitter model / monitor state
  bit         model_en = 0;
  bit         pend = 0;
  int         cnt = 0;
  int         tickno = 0;
  int         fall_tick = 0;
  bit         fall_valid = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] pd_prev = 8'h00;
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample just after the edge, run protocol monitors, step the model.
  task automatic tick();
    logic b_in;
    logic old_b;
    b_in = bus.Busy;
    @(posedge clk);
    #1;
    tickno++;
    if (bus.DATA_VALID) begin
      chk("dv_while_busy", 32'(b_in), 0);
      chk("dv_one_cycle", 32'(dv_prev), 0);
      if (model_en) begin
        rx.push_back(bus.P_DATA);
        if (fall_valid) chk("issue_gap", 32'(tickno - fall_tick >= 2), 1);
        fall_valid = 0;
      end
    end
    if (b_in) chk("pdata_stable", 32'(bus.P_DATA), 32'(pd_prev));
    dv_prev = bus.DATA_VALID;
    pd_prev = bus.P_DATA;
    if (model_en) begin
      old_b = bus.Busy;
      if (pend) begin
        cnt  = 10;
        pend = 0;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (bus.DATA_VALID) pend = 1;
      bus.Busy = (cnt > 0);
      if (old_b && !bus.Busy) begin
        fall_tick  = tickno;
        fall_valid = 1;
      end
    end
  endtask

  // Run until n words received and the model has gone quiet, bounded.
  task automatic drain(input int n, input int budget);
    int k;
    k = 0;
    while ((rx.size() < n || cnt > 0 || pend) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_in_budget", 32'(k < budget), 1);
    repeat (3) tick();
  endtask

  task automatic cmp_rx(input string name);
    chk({name, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), (i < rx.size()) ? 32'(rx[i]) : 32'hdead, 32'(exp_q[i]));
  endtask

  task automatic model_on();
    model_en   = 1;
    cnt        = 0;
    pend       = 0;
    fall_valid = 0;
    bus.Busy   = 1'b0;
    rx.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, k;

    // ---- vector table ----
    // single word, latency and handshake
    tbl[0] = '{1, 8'hA5, 0, 0,  0, 8'h00, 4'd1, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 0, 0,  1, 8'hA5, 4'd0, 0, 1, 0};
    tbl[2] = '{0, 8'h00, 0, 0,  0, 8'hA5, 4'd0, 0, 1, 0};
    tbl[3] = '{0, 8'h00, 1, 0,  0, 8'hA5, 4'd0, 0, 1, 0};
    tbl[4] = '{0, 8'h00, 0, 0,  0, 8'hA5, 4'd0, 0, 1, 0};
    // fill while the transmitter is busy
    for (int i = 0; i < 8; i++)
      tbl[5+i] = '{1, 8'(8'h10 + i), 1, 0, 0, 8'hA5, 4'(i + 1), (i == 7), 0, 0};
    // Busy drops while full: pop happens, the same-cycle write is still dropped
    tbl[13] = '{1, 8'hEE, 0, 0,  1, 8'h10, 4'd7, 0, 0, 1};
    tbl[14] = '{0, 8'h00, 0, 0,  0, 8'h10, 4'd7, 0, 0, 1};
    tbl[15] = '{0, 8'h00, 0, 1,  0, 8'h10, 4'd7, 0, 0, 0};

    // ---- reset ----
    rst_n = 1'b0;
    bus.WR_EN = 1'b0; bus.WR_DATA = 8'h00; bus.Busy = 1'b0; bus.OVF_CLR = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv",    32'(bus.DATA_VALID), 0);
    chk("rst_pdata", 32'(bus.P_DATA), 0);
    chk("rst_count", 32'(bus.COUNT), 0);
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_full",  32'(bus.FULL), 0);
    chk("rst_ovf",   32'(bus.OVF), 0);
    #2 rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      bus.WR_EN   = tbl[i].wr;
      bus.WR_DATA = tbl[i].wd;
      bus.Busy    = tbl[i].busy;
      bus.OVF_CLR = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_dv", i),    32'(bus.DATA_VALID), 32'(tbl[i].dv));
      chk($sformatf("v%0d_pdata", i), 32'(bus.P_DATA),     32'(tbl[i].pd));
      chk($sformatf("v%0d_count", i), 32'(bus.COUNT),      32'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i),  32'(bus.FULL),       32'(tbl[i].full));
      chk($sformatf("v%0d_empty", i), 32'(bus.EMPTY),      32'(tbl[i].empty));
      chk($sformatf("v%0d_ovf", i),   32'(bus.OVF),        32'(tbl[i].ovf));
    end
    bus.WR_EN = 1'b0; bus.OVF_CLR = 1'b0;

    // drain the remaining 7; the transmitter already saw the 0x10 pulse
    model_on();
    pend = 1;
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    drain(7, 400);
    cmp_rx("collide");

    // ---- three back-to-back words ----
    model_on();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = exp_q[i];
      tick();
    end
    bus.WR_EN = 1'b0;
    drain(3, 200);
    cmp_rx("b2b");

    // ---- fill to FULL with Busy held, overflow, then release ----
    model_en = 0; bus.Busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = 8'(8'h80 + i);
      tick();
    end
    chk("fill_full",  32'(bus.FULL), 1);
    chk("fill_count", 32'(bus.COUNT), 8);
    chk("fill_ovf",   32'(bus.OVF), 0);
    bus.WR_DATA = 8'h99;
    tick();
    bus.WR_EN = 1'b0;
    chk("ovf_set",   32'(bus.OVF), 1);
    chk("ovf_count", 32'(bus.COUNT), 8);
    model_on();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h80 + i));
    drain(8, 600);
    cmp_rx("full");
    chk("ovf_sticky", 32'(bus.OVF), 1);
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(bus.OVF), 0);

    // ---- pointer wrap: 20 words with continuous refill ----
    model_on();
    sent = 0; k = 0;
    while (rx.size() < 20 && k < 3000) begin
      if (sent < 20 && !bus.FULL) begin
        bus.WR_EN = 1'b1; bus.WR_DATA = 8'(sent * 37 + 5);
        exp_q.push_back(8'(sent * 37 + 5));
        sent++;
      end else begin
        bus.WR_EN = 1'b0;
      end
      tick();
      k++;
    end
    bus.WR_EN = 1'b0;
    chk("wrap_in_budget", 32'(k < 3000), 1);
    drain(20, 300);
    cmp_rx("wrap");
    chk("wrap_empty", 32'(bus.EMPTY), 1);

    // ---- reset while in WAIT_DONE with 4 buffered ----
    model_on();
    for (int i = 0; i < 5; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = 8'(8'h50 + i);
      tick();
    end
    bus.WR_EN = 1'b0;
    k = 0;
    while (!(bus.Busy && cnt < 9) && k < 50) begin
      tick();
      k++;
    end
    chk("pre_rst_busy",  32'(bus.Busy), 1);
    chk("pre_rst_count", 32'(bus.COUNT), 4);
    chk("pre_rst_pdata", 32'(bus.P_DATA), 8'h50);
    #2 rst_n = 1'b0;
    model_en = 0; cnt = 0; pend = 0; bus.Busy = 1'b0;
    #1;
    chk("mid_rst_dv",    32'(bus.DATA_VALID), 0);
    chk("mid_rst_pdata", 32'(bus.P_DATA), 0);
    chk("mid_rst_count", 32'(bus.COUNT), 0);
    chk("mid_rst_empty", 32'(bus.EMPTY), 1);
    chk("mid_rst_full",  32'(bus.FULL), 0);
    chk("mid_rst_ovf",   32'(bus.OVF), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    dv_prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_dv%0d", i), 32'(bus.DATA_VALID), 0);
    end
    chk("post_rst_empty", 32'(bus.EMPTY), 1);
    model_on();
    exp_q.push_back(8'h77);
    bus.WR_EN = 1'b1; bus.WR_DATA = 8'h77;
    tick();
    bus.WR_EN = 1'b0;
    drain(1, 100);
    cmp_rx("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
